divider_6bit: RTL
=================

DIVIDER_6BIT -- requirements
Module: divider_6bit

Interface
REQ-001 The block SHALL have one parameter: N, default 6, operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port M, input, N bits: unsigned dividend; sampled on the edge that accepts start.
REQ-006 The block SHALL have port Q, input, N bits: unsigned divisor; sampled on the edge that accepts start.
REQ-007 The block SHALL have port quot, output, N bits: unsigned quotient floor(M/Q).
REQ-008 The block SHALL have port rem, output, N bits: unsigned remainder M mod Q.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is in progress (CALC or DONE).
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse; quot/rem/div_by_zero valid.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: the result just completed had Q == 0.

Function
REQ-012 The block SHALL implement three states, IDLE, CALC and DONE, using sequential restoring division with one quotient bit per clock.
REQ-013 IDLE SHALL behave as follows: on an edge with start=1, latch M and Q, clear the partial remainder (N+1 bits), load the iteration counter with 0, and go to CALC; otherwise stay in IDLE.
REQ-014 Each CALC edge SHALL: shift {partial remainder, dividend shift register} left 1 bit; trial-subtract the divisor from the partial remainder; if the result is non-negative, keep it and shift in a quotient bit of 1, else restore and shift in 0; increment the counter.
REQ-015 The block SHALL perform exactly N iterations; on the edge performing iteration N it SHALL register quot, rem and div_by_zero and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, and SHALL then return to IDLE unconditionally.
REQ-017 Latency SHALL be: start accepted at edge 0, done high in the cycle after edge N (N=6: done asserted 6 edges after acceptance; next start accepted at edge N+2 at the earliest).
REQ-018 start SHALL be ignored in CALC and DONE; operands applied then SHALL NOT affect the result in flight.
REQ-019 quot, rem and div_by_zero SHALL hold their last values from the DONE edge until the next completion; they SHALL NOT change during CALC.
REQ-020 For Q == 0, the block SHALL run the normal N-cycle path and produce quot = all ones, rem = M, and div_by_zero = 1.
REQ-021 Arithmetic rules: the trial subtraction SHALL be N+1 bits wide, so the carry out of the shifted remainder is never lost; for all Q != 0 the outputs SHALL satisfy quot*Q + rem == M and rem < Q.
REQ-022 busy SHALL be 1 in CALC and DONE and 0 in IDLE; done SHALL be 1 only in DONE.

Reset
REQ-023 While rst=1, independent of clk, the block SHALL force state=IDLE, counter=0, partial remainder=0, quot=0, rem=0, busy=0, done=0, div_by_zero=0.
REQ-024 A reset asserted mid-CALC or in DONE SHALL abort the division with no done pulse; after rst deasserts, the first edge with start=1 SHALL begin a fresh division.

Verification
REQ-025 The bench SHALL cover: M=45, Q=6, start pulse -> done exactly 6 edges later with quot=7, rem=3, div_by_zero=0.
REQ-026 The bench SHALL cover: M=63, Q=1 -> quot=63, rem=0; and M=0, Q=7 -> quot=0, rem=0.
REQ-027 The bench SHALL cover: M=5, Q=0 -> quot=63, rem=5, div_by_zero=1 with the same 6-cycle latency.
REQ-028 The bench SHALL cover: start=1 held continuously with M/Q changed during CALC -> result matches operands at acceptance; next acceptance occurs on the edge after DONE.
REQ-029 The bench SHALL cover: rst pulsed at iteration 3 -> busy=0, done never pulses, all outputs 0; new start with M=20, Q=3 -> quot=6, rem=2.
REQ-030 The bench SHALL cover: exhaustive sweep of all 64x64 operand pairs against the reference model floor/mod, with busy/done timing checked on every transaction.

Source files
------------

// File: rtl/divider_6bit.sv
// divider_6bit: sequential restoring divider for unsigned N-bit operands.
// One quotient bit is resolved per clock in CALC, so a division takes N
// CALC edges, then a single DONE cycle that pulses done.
//
// Handshake: start is sampled only in IDLE (busy=0); the edge that sees
// start=1 in IDLE captures M and Q. Until the matching done pulse, start
// and the operand inputs are ignored. quot, rem and div_by_zero are
// registered on the last CALC edge and hold until the next completion.
module divider_6bit #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] M,
  input  logic [N-1:0] Q,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    prem_q;   // partial remainder, one bit wider than operands
  logic [N-1:0]  dvd_q;    // dividend bits shift out the top, quotient bits in the bottom
  logic [N-1:0]  dvs_q;    // divisor captured at acceptance
  logic [N-1:0]  quot_q;
  logic [N-1:0]  rem_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_q;

  // One restoring-division step, computed from the current registers
  logic [N:0]    shifted;
  logic [N+1:0]  trial;
  logic          fits;
  logic [N:0]    prem_d;
  logic [N-1:0]  dvd_d;
  logic          last_iter;

  // Shift remainder/dividend left, trial-subtract the divisor, restore on borrow
  always_comb begin
    shifted   = {prem_q[N-1:0], dvd_q[N-1]};
    trial     = {1'b0, shifted} - {2'b00, dvs_q};
    // A set top bit in the remainder would mean the shifted value exceeds any
    // divisor; it never occurs because the remainder stays below the divisor.
    fits      = ~trial[N+1] | prem_q[N];
    prem_d    = fits ? trial[N:0] : shifted;
    dvd_d     = {dvd_q[N-2:0], fits};
    last_iter = (cnt_q == CW'(N - 1));
  end

  // Control FSM with all state and outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= M;
            dvs_q   <= Q;
            prem_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_CALC: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_iter) begin
            quot_q  <= dvd_d;
            rem_q   <= prem_d[N-1:0];
            dbz_q   <= (dvs_q == '0);
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule
